reduce_modp_seq: RTL
====================

// Module: reduce_modp_seq
// PURPOSE
//  Sequential reduction of a 2W-bit integer modulo p = 2^W - C (default 2^255 - 19).
//  Sits directly downstream of the sequential N x N multiplier; consumes its 2W-bit product, returns the canonical residue in [0, p).
//  Registered two-fold pseudo-Mersenne reduction plus one conditional subtract; valid/ready on both sides.
// PARAMETERS
//  W  255  field width in bits; p = 2^W - C
//  C  19   pseudo-Mersenne constant; 1 <= C < 2^6, so C*(2^6) < p
// PORTS
//  clk        in   1    clock, rising edge
//  rst        in   1    reset, asynchronous, active-low
//  in_valid   in   1    in_data valid
//  in_ready   out  1    block accepts in_data this cycle
//  in_data    in   2W   unsigned value to reduce (multiplier product)
//  out_valid  out  1    out_data holds a finished residue
//  out_ready  in   1    consumer takes out_data this cycle
//  out_data   out  W    in_data mod p, canonical (< p)
//  busy       out  1    high in any state other than IDLE
// BEHAVIOUR
//  Reset (async, rst=0): state=IDLE, r='0, out_data='0, out_valid=0, busy=0; in_ready=1 once rst released.
//  FSM: IDLE -> FOLD1 -> FOLD2 -> CSUB -> DONE -> IDLE; one transaction in flight, no overlap.
//  IDLE: in_ready=1. On in_valid&&in_ready at edge k: r <= in_data, state <= FOLD1.
//  FOLD1 (edge k+1): r <= r[W-1:0] + C*r[2W-1:W]; result < 2^(W+6), upper bits zeroed.
//  FOLD2 (edge k+2): r <= r[W-1:0] + C*r[W+5:W]; result < 2^W + 63*C < 2p.
//  CSUB (edge k+3): out_data <= (r >= p) ? r - p : r[W-1:0]; out_valid <= 1; state <= DONE.
//  DONE: out_valid=1, out_data held stable until out_ready. On out_valid&&out_ready: out_valid <= 0, state <= IDLE.
//  Latency: out_valid rises at edge k+3 (3 cycles after acceptance). Minimum initiation interval: 5 cycles.
//  in_ready is combinational from state only (IDLE), never from in_valid. out_valid is registered.
//  in_valid while not IDLE: ignored, no effect. in_data is sampled only at acceptance; may change afterwards.
//  out_ready while out_valid=0: ignored. out_ready held low: the block waits in DONE indefinitely; in_ready stays low.
//  All arithmetic is unsigned. Intermediate r is W+6 bits after FOLD1. Comparison against p uses the full width; no truncation before CSUB.
//  Reset mid-operation (any state): immediate return to reset values; the in-flight value is discarded, no partial output.
//  Both folds are always executed, even when the upper bits are zero; the fixed latency is data-independent.
// STRUCTURE
//  Package modp_pkg: localparams W, C, P = 2^W - C, IN_W = 2*W; typedef enum logic [2:0] {IDLE, FOLD1, FOLD2, CSUB, DONE} redc_state_t.
//  Sub-module fold_c (combinational): lo[W-1:0] + C*hi, with hi width as a parameter; C*hi built as shift-add (19h = 16h + 2h + h).
//    Instantiated once and muxed between FOLD1 (hi = r[2W-1:W]) and FOLD2 (hi = r[W+5:W]).
//  Top: FSM, r register, conditional subtract, output register, handshake.
// TESTING
//  1. in_data=0 -> out_data=0; out_valid rises exactly 3 cycles after acceptance edge.
//  2. in_data=p -> 0; in_data=p-1 -> p-1; in_data=2^255 -> 19; in_data=2^255+18 -> 37.
//  3. in_data=(p-1)^2 -> 1; in_data=2^510-1 -> 360 (2^510 = 361 mod p).
//  4. out_ready low for 10 cycles after out_valid: out_valid and out_data are stable, in_ready=0, a new in_valid is ignored; then out_ready=1 -> IDLE the next cycle.
//  5. rst pulsed low while in FOLD2: outputs go to reset values at once, no out_valid. Next transaction (in=2^255) -> 19 with correct timing.
//  6. Back-to-back: 1000 random 510-bit inputs with random out_ready stalls; compare against a mod-p reference model; every output is < p.

Source files
------------

// File: rtl/modp_pkg.sv
// Shared constants and state encoding for the pseudo-Mersenne reducer.
package modp_pkg;

  localparam int W    = 255;
  localparam int C    = 19;
  localparam int IN_W = 2 * W;
  // 2^W - C written as (2^W - 1) - (C - 1) so it fits in W bits.
  localparam logic [W-1:0] P = {W{1'b1}} - W'(C - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FOLD1 = 3'd1,
    FOLD2 = 3'd2,
    CSUB  = 3'd3,
    DONE  = 3'd4
  } redc_state_t;

endpackage

// File: rtl/fold_c.sv
// Combinational pseudo-Mersenne fold: sum = lo + C*hi.
// C*hi is built by shift-add over the set bits of C (19h = 16h + 2h + h).
module fold_c #(
  parameter int W    = 255,
  parameter int C    = 19,
  parameter int HI_W = 255
) (
  input  logic [W-1:0]    lo,
  input  logic [HI_W-1:0] hi,
  output logic [HI_W+5:0] sum
);

  localparam logic [5:0] C_BITS = C[5:0];

  logic [HI_W+5:0] prod;

  // Shift-add multiply by the 6-bit constant, then add the low half.
  always_comb begin
    prod = '0;
    for (int i = 0; i < 6; i++) begin
      if (C_BITS[i]) prod = prod + ({6'b0, hi} << i);
    end
    sum = {{(HI_W + 6 - W){1'b0}}, lo} + prod;
  end

endmodule

// File: rtl/reduce_modp_seq.sv
// Sequential reduction of a 2W-bit product modulo p = 2^W - C.
// Two registered folds bring the value below 2p, a final conditional
// subtract makes it canonical. One transaction in flight at a time.
//
//  state | meaning
//  IDLE  | waiting for in_valid, in_ready high
//  FOLD1 | r <= r_lo + C*r_hi (full W-bit upper half)
//  FOLD2 | r <= r_lo + C*r[W+5:W] (6-bit carry-out of FOLD1)
//  CSUB  | out_data <= r mod p via one conditional subtract
//  DONE  | out_valid held until out_ready
module reduce_modp_seq
  import modp_pkg::*;
#(
  parameter int W = modp_pkg::W,
  parameter int C = modp_pkg::C
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*W-1:0] in_data,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [W-1:0]   out_data,
  output logic           busy
);

  localparam logic [W-1:0] P_MOD = {W{1'b1}} - W'(C - 1);

  redc_state_t state, state_n;

  logic [2*W-1:0] r;
  logic [W-1:0]   fold_hi;
  logic [W+5:0]   fold_sum;
  logic [W-1:0]   diff;
  logic           ge_p;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // FOLD1 folds the whole upper half; FOLD2 only the 6 bits it can leave behind.
  assign fold_hi = (state == FOLD1) ? r[2*W-1:W] : {{(W - 6){1'b0}}, r[W+5:W]};

  fold_c #(
    .W   (W),
    .C   (C),
    .HI_W(W)
  ) u_fold (
    .lo (r[W-1:0]),
    .hi (fold_hi),
    .sum(fold_sum)
  );

  // r < 2p here, so r - p fits in W bits and only the low half is needed.
  assign ge_p = (r >= {{W{1'b0}}, P_MOD});
  assign diff = r[W-1:0] - P_MOD;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_n;
  end

  // Next-state logic: fixed three-step pipeline, then wait for the consumer.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = FOLD1;
      FOLD1:   state_n = FOLD2;
      FOLD2:   state_n = CSUB;
      CSUB:    state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Datapath: working register, output register and out_valid.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r         <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) r <= in_data;
        end
        FOLD1, FOLD2: begin
          r <= {{(W - 6){1'b0}}, fold_sum};
        end
        CSUB: begin
          out_data  <= ge_p ? diff : r[W-1:0];
          out_valid <= 1'b1;
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
